// File: rtl/latch_write_arbiter_pkg.sv
// latch_write_arbiter_pkg
// Shared definitions for the latch write arbiter: FSM state encoding, the
// width of the enable-window down-counter and a small width helper.
// No ports.

package latch_write_arbiter_pkg;

    // Binary, 2-bit state encoding of the write sequencer.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // The enable counter holds EN_CYCLES-1; EN_CYCLES tops out at 4.
    localparam int unsigned EN_CNT_W = 2;

    // Index width for n items, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latch_write_arbiter_if.sv
// latch_write_arbiter_if
// Bundles the requester-side write ports and the bank-side latch drive of
// the arbiter.
//   req, req_addr, req_data : per-requester write request, flat-packed
//   ack                     : one-cycle completion pulse per requester
//   busy, gnt_id            : sequencer status and current/last grantee
//   lat_d, lat_en           : shared data bus and one-hot latch enables
// Modports: master = requesters/bench, slave = arbiter.

interface latch_write_arbiter_if
    import latch_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 2
);
    localparam int unsigned IDW   = id_width(NREQ);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [IDW-1:0]        gnt_id;
    logic [WIDTH-1:0]      lat_d;
    logic [DEPTH-1:0]      lat_en;

    modport master (
        output req, req_addr, req_data,
        input  ack, busy, gnt_id, lat_d, lat_en
    );

    modport slave (
        input  req, req_addr, req_data,
        output ack, busy, gnt_id, lat_d, lat_en
    );

endinterface

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick. Search starts at ptr and moves upward,
// wrapping modulo NREQ; the first set req bit wins.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   valid  : at least one request is set
//   winner : index of the selected requester

module rr_arbiter
    import latch_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    logic [IDW-1:0] idx;

    // Walk from the farthest offset down to ptr so the nearest set bit is
    // the last one assigned.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr) + i) % int'(NREQ));
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
// Round-robin write arbiter and enable sequencer for a bank of gated D
// latches. Each granted write runs SETUP (data on the bus, enables low),
// ENABLE (one enable high for EN_CYCLES cycles), HOLD (enables low, ack).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of latch_write_arbiter_if (requests in, latch drive out)

module latch_write_arbiter
    import latch_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AW        = 2,
    parameter int unsigned EN_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    latch_write_arbiter_if.slave bus
);

    localparam int unsigned IDW   = id_width(NREQ);
    localparam int unsigned DEPTH = 2 ** AW;

    if (EN_CYCLES < 1 || EN_CYCLES > 4) begin : g_bad_en_cycles
        $error("EN_CYCLES must be in 1..4");
    end

    state_t                state_q;
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        gnt_q;
    logic [AW-1:0]         addr_q;
    logic [WIDTH-1:0]      data_q;
    logic [DEPTH-1:0]      en_q;
    logic [NREQ-1:0]       ack_q;
    logic                  busy_q;
    logic [EN_CNT_W-1:0]   cnt_q;

    logic                  win_valid;
    logic [IDW-1:0]        win;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req    (bus.req),
        .ptr    (ptr_q),
        .valid  (win_valid),
        .winner (win)
    );

    // Every output leaves this block straight from a register; outputs take
    // the value of a state on the edge that enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        // Address and data are frozen here; later changes
                        // on the request ports do not reach the bank.
                        gnt_q   <= win;
                        addr_q  <= bus.req_addr[win*AW +: AW];
                        data_q  <= bus.req_data[win*WIDTH +: WIDTH];
                        ptr_q   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    en_q         <= '0;
                    en_q[addr_q] <= 1'b1;
                    cnt_q        <= EN_CNT_W'(EN_CYCLES - 1);
                    state_q      <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    if (cnt_q == '0) begin
                        en_q         <= '0;
                        ack_q[gnt_q] <= 1'b1;
                        state_q      <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    en_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack    = ack_q;
    assign bus.busy   = busy_q;
    assign bus.gnt_id = gnt_q;
    assign bus.lat_d  = data_q;
    assign bus.lat_en = en_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter
// Self-checking bench: one arbiter with EN_CYCLES=1 and one with
// EN_CYCLES=3. Expected writes are queued when requests are driven and
// retired against each ack pulse; scenario tasks also check cycle timing.

module tb_latch_write_arbiter;
    import latch_write_arbiter_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned SW    = WIDTH + DEPTH + NREQ + 1 + IDW;

    typedef struct {
        int unsigned      id;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    latch_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus1 ();
    latch_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus3 ();

    latch_write_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .EN_CYCLES(1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    latch_write_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .EN_CYCLES(3)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    exp_t            q1[$];
    exp_t            q3[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    bit              sticky   = 1'b0;
    logic [NREQ-1:0] drop1    = '0;
    logic [NREQ-1:0] drop3    = '0;
    logic [SW-1:0]   got;
    logic [SW-1:0]   exp;

    task automatic set_req1(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus1.req_addr[i*AW +: AW]       = a;
        bus1.req_data[i*WIDTH +: WIDTH] = d;
    endtask

    // Retire queued writes against ack pulses and check enables on the fly.
    task automatic scoreboard_sample();
        exp_t e;
        if (bus1.lat_en !== '0) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL sb1_lat_en: lat_en=%b, expected 0000 (no write pending)", bus1.lat_en);
            end else if (bus1.lat_en !== (4'(1) << q1[0].addr)) begin
                n_fail++;
                $display("FAIL sb1_lat_en: lat_en=%b, expected %b", bus1.lat_en,
                         4'(1) << q1[0].addr);
            end
        end
        if (bus1.ack !== '0) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL sb1_ack: ack=%b, expected 0000 (no write pending)", bus1.ack);
            end else begin
                e = q1.pop_front();
                if (bus1.ack !== (4'(1) << e.id) || bus1.gnt_id !== IDW'(e.id)
                    || bus1.lat_d !== e.data) begin
                    n_fail++;
                    $display("FAIL sb1_write: ack=%b gnt=%0d d=%h, expected ack=%b gnt=%0d d=%h",
                             bus1.ack, bus1.gnt_id, bus1.lat_d, 4'(1) << e.id, e.id, e.data);
                end
            end
        end
        if (bus3.lat_en !== '0) begin
            n_checks++;
            if (q3.size() == 0 || bus3.lat_en !== (4'(1) << q3[0].addr)) begin
                n_fail++;
                $display("FAIL sb3_lat_en: lat_en=%b unexpected (queue depth %0d)",
                         bus3.lat_en, q3.size());
            end
        end
        if (bus3.ack !== '0) begin
            n_checks++;
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL sb3_ack: ack=%b, expected 0000 (no write pending)", bus3.ack);
            end else begin
                e = q3.pop_front();
                if (bus3.ack !== (4'(1) << e.id) || bus3.lat_d !== e.data) begin
                    n_fail++;
                    $display("FAIL sb3_write: ack=%b d=%h, expected ack=%b d=%h",
                             bus3.ack, bus3.lat_d, 4'(1) << e.id, e.data);
                end
            end
        end
    endtask

    // One clock: requesters drop req the edge after their ack, then sample.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!sticky) begin
            bus1.req = bus1.req & ~drop1;
            bus3.req = bus3.req & ~drop3;
        end
        @(negedge clk);
        drop1 = bus1.ack;
        drop3 = bus3.ack;
        scoreboard_sample();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus1.req = '0;
        bus3.req = '0;
        q1.delete();
        q3.delete();
        drop1 = '0;
        drop3 = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        got = {bus1.lat_d, bus1.lat_en, bus1.ack, bus1.busy, bus1.gnt_id};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: {d,en,ack,busy,gnt}=%h, expected 0", got);
        end
        got = {bus3.lat_d, bus3.lat_en, bus3.ack, bus3.busy, bus3.gnt_id};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_dut3: {d,en,ack,busy,gnt}=%h, expected 0", got);
        end
        tick();
        n_checks++;
        if (bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b, expected 0", bus1.busy);
        end
    endtask

    // Single write; optionally change the request data after the grant.
    task automatic test_write(input string name, input bit change_data);
        set_req1(0, 2'd2, 8'hA5);
        bus1.req = 4'b0001;
        q1.push_back('{0, 2'd2, 8'hA5});
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (change_data && k == 1) set_req1(0, 2'd2, 8'h3C);
            got = {bus1.lat_d, bus1.lat_en, bus1.ack, bus1.busy, bus1.gnt_id};
            exp = {8'hA5, (k == 2) ? 4'b0100 : 4'b0000, (k == 3) ? 4'b0001 : 4'b0000,
                   (k <= 3), 2'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s c%0d: {d,en,ack,busy,gnt}=%h, expected %h", name, k, got, exp);
            end
        end
    endtask

    task automatic test_contention();
        int unsigned ids[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) set_req1(i, AW'(3 - i), 8'h10 + 8'(i));
        for (int s = 0; s < 5; s++) q1.push_back('{ids[s], AW'(3 - ids[s]), 8'h10 + 8'(ids[s])});
        sticky   = 1'b1;
        bus1.req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (c == 1) begin
                    n_checks++;
                    if (bus1.gnt_id !== IDW'(ids[s]) || bus1.busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL contention_gnt s%0d: gnt=%0d busy=%b, expected gnt=%0d busy=1",
                                 s, bus1.gnt_id, bus1.busy, ids[s]);
                    end
                end
                if (c == 3) begin
                    n_checks++;
                    if (bus1.ack !== (4'(1) << ids[s])) begin
                        n_fail++;
                        $display("FAIL contention_ack s%0d: ack=%b, expected %b",
                                 s, bus1.ack, 4'(1) << ids[s]);
                    end
                    if (s == 4) bus1.req = '0;
                end
            end
        end
        sticky = 1'b0;
        drop1  = '0;
    endtask

    task automatic test_wrap_around();
        set_req1(3, 2'd1, 8'h77);
        bus1.req = 4'b1000;
        q1.push_back('{3, 2'd1, 8'h77});
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if (bus1.gnt_id !== 2'd3) begin
                    n_fail++;
                    $display("FAIL wrap_first: gnt=%0d, expected 3", bus1.gnt_id);
                end
            end
        end
        set_req1(0, 2'd0, 8'h01);
        bus1.req = 4'b1001;
        q1.push_back('{0, 2'd0, 8'h01});
        q1.push_back('{3, 2'd1, 8'h77});
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1 || k == 5) begin
                n_checks++;
                if (bus1.gnt_id !== ((k == 1) ? 2'd0 : 2'd3)) begin
                    n_fail++;
                    $display("FAIL wrap_order c%0d: gnt=%0d, expected %0d", k, bus1.gnt_id,
                             (k == 1) ? 0 : 3);
                end
            end
        end
    endtask

    task automatic test_en_cycles3();
        bus3.req_addr[0 +: AW]    = 2'd1;
        bus3.req_data[0 +: WIDTH] = 8'h5A;
        bus3.req = 4'b0001;
        q3.push_back('{0, 2'd1, 8'h5A});
        for (int k = 1; k <= 7; k++) begin
            tick();
            got = {bus3.lat_d, bus3.lat_en, bus3.ack, bus3.busy, bus3.gnt_id};
            exp = {8'h5A, (k >= 2 && k <= 4) ? 4'b0010 : 4'b0000,
                   (k == 5) ? 4'b0001 : 4'b0000, (k <= 5), 2'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL en3 c%0d: {d,en,ack,busy,gnt}=%h, expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_enable();
        do_reset();
        set_req1(2, 2'd3, 8'hC3);
        bus1.req = 4'b0100;
        q1.push_back('{2, 2'd3, 8'hC3});
        tick();
        tick();
        n_checks++;
        if (bus1.lat_en !== 4'b1000 || bus1.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_enable: en=%b busy=%b, expected en=1000 busy=1",
                     bus1.lat_en, bus1.busy);
        end
        rst      = 1'b1;
        bus1.req = '0;
        q1.delete();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({bus1.lat_en, bus1.ack, bus1.busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_after: en=%b ack=%b busy=%b, expected all 0",
                     bus1.lat_en, bus1.ack, bus1.busy);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (bus1.ack !== '0 || bus1.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet c%0d: ack=%b busy=%b, expected 0000 and 0",
                         k, bus1.ack, bus1.busy);
            end
        end
        set_req1(0, 2'd0, 8'h11);
        set_req1(3, 2'd3, 8'h33);
        bus1.req = 4'b1001;
        q1.push_back('{0, 2'd0, 8'h11});
        q1.push_back('{3, 2'd3, 8'h33});
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1 || k == 5) begin
                n_checks++;
                if (bus1.gnt_id !== ((k == 1) ? 2'd0 : 2'd3)) begin
                    n_fail++;
                    $display("FAIL rstmid_regrant c%0d: gnt=%0d, expected %0d", k, bus1.gnt_id,
                             (k == 1) ? 0 : 3);
                end
            end
        end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending writes dut1=%0d dut3=%0d, expected 0 and 0",
                     q1.size(), q3.size());
        end
    endtask

    initial begin
        bus1.req      = '0;
        bus1.req_addr = '0;
        bus1.req_data = '0;
        bus3.req      = '0;
        bus3.req_addr = '0;
        bus3.req_data = '0;
        test_reset();
        test_write("single_write", 1'b0);
        test_write("data_change", 1'b1);
        test_contention();
        test_wrap_around();
        test_en_cycles3();
        test_reset_mid_enable();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
